alu_exec: RTL and testbench

- Execute stage sitting directly downstream of REG_FILE.
- Consumes the register file's A/B read data and produces the write-back data, destination address and write strobe that feed the register file's X/XADDR/write inputs.
- Single-cycle logic/arithmetic ops plus an iterative 8-cycle shift-add multiply, sequenced by a small FSM with start/busy/done handshake.

---
 rtl/alu_exec.sv | 196 +++++++++++++++++++
 tb/tb_alu_exec.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec.sv
// Execute stage behind the register file: single-cycle ALU ops plus an
// iterative shift-add multiply, with a start/busy/done handshake and registered write-back.
module alu_exec #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [WIDTH-1:0]  A,
  input  logic [WIDTH-1:0]  B,
  input  logic [ADDR_W-1:0] dst,
  output logic [WIDTH-1:0]  X,
  output logic [ADDR_W-1:0] XADDR,
  output logic              write,
  output logic              busy,
  output logic              done,
  output logic              zero,
  output logic              carry
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MUL  = 2'd2,
    WB   = 2'd3
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic [2:0]          op_r;
  logic [WIDTH-1:0]    a_r;
  logic [WIDTH-1:0]    b_r;
  logic [ADDR_W-1:0]   dst_r;
  logic [CW-1:0]       cnt_r;
  logic [2*WIDTH-1:0]  a_sh_r;
  logic [2*WIDTH-1:0]  acc_r;

  logic [WIDTH:0]      sum_s;
  logic [WIDTH:0]      diff_s;
  logic [WIDTH-1:0]    alu_res_s;
  logic                alu_carry_s;
  logic [2*WIDTH-1:0]  mul_add_s;
  logic [2*WIDTH-1:0]  acc_nxt_s;
  logic                mul_carry_s;
  logic                last_step_s;

  // Single-cycle ALU result and flag from the latched operands
  always_comb begin
    sum_s       = {1'b0, a_r} + {1'b0, b_r};
    diff_s      = {1'b0, a_r} - {1'b0, b_r};
    alu_res_s   = {WIDTH{1'b0}};
    alu_carry_s = 1'b0;
    case (op_r)
      3'b000: begin
        alu_res_s   = sum_s[WIDTH-1:0];
        alu_carry_s = sum_s[WIDTH];
      end
      3'b001: begin
        // the extra top bit of the widened difference is the borrow
        alu_res_s   = diff_s[WIDTH-1:0];
        alu_carry_s = diff_s[WIDTH];
      end
      3'b010: alu_res_s = a_r & b_r;
      3'b011: alu_res_s = a_r | b_r;
      3'b100: alu_res_s = a_r ^ b_r;
      3'b101: begin
        alu_res_s   = {a_r[WIDTH-2:0], 1'b0};
        alu_carry_s = a_r[WIDTH-1];
      end
      3'b110: begin
        alu_res_s   = {1'b0, a_r[WIDTH-1:1]};
        alu_carry_s = a_r[0];
      end
      default: begin
        alu_res_s   = {WIDTH{1'b0}};
        alu_carry_s = 1'b0;
      end
    endcase
  end

  // One shift-add multiply step
  always_comb begin
    if (b_r[0]) begin
      mul_add_s = a_sh_r;
    end else begin
      mul_add_s = {(2*WIDTH){1'b0}};
    end
    acc_nxt_s   = acc_r + mul_add_s;
    mul_carry_s = |acc_nxt_s[2*WIDTH-1:WIDTH];
    last_step_s = (cnt_r == LAST_STEP);
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          if (op == 3'b111) begin
            state_nxt_s = MUL;
          end else begin
            state_nxt_s = EXEC;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      EXEC: state_nxt_s = WB;
      MUL: begin
        if (last_step_s) begin
          state_nxt_s = WB;
        end else begin
          state_nxt_s = MUL;
        end
      end
      WB:      state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register and handshake outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= IDLE;
      write   <= 1'b0;
      done    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      write   <= (state_nxt_s == WB);
      done    <= (state_nxt_s == WB);
      busy    <= (state_nxt_s != IDLE);
    end
  end

  // Operand capture and multiply iteration registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      op_r   <= 3'b000;
      a_r    <= {WIDTH{1'b0}};
      b_r    <= {WIDTH{1'b0}};
      dst_r  <= {ADDR_W{1'b0}};
      cnt_r  <= {CW{1'b0}};
      a_sh_r <= {(2*WIDTH){1'b0}};
      acc_r  <= {(2*WIDTH){1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            op_r   <= op;
            a_r    <= A;
            b_r    <= B;
            dst_r  <= dst;
            cnt_r  <= {CW{1'b0}};
            a_sh_r <= {{WIDTH{1'b0}}, A};
            acc_r  <= {(2*WIDTH){1'b0}};
          end
        end
        MUL: begin
          acc_r  <= acc_nxt_s;
          a_sh_r <= a_sh_r << 1;
          b_r    <= b_r >> 1;
          cnt_r  <= cnt_r + CW'(1);
        end
        default: begin
        end
      endcase
    end
  end

  // Result, address and flags; held until the next op's result edge
  always_ff @(posedge clk) begin
    if (!rst) begin
      X     <= {WIDTH{1'b0}};
      XADDR <= {ADDR_W{1'b0}};
      zero  <= 1'b0;
      carry <= 1'b0;
    end else if (state_r == EXEC) begin
      X     <= alu_res_s;
      XADDR <= dst_r;
      zero  <= (alu_res_s == {WIDTH{1'b0}});
      carry <= alu_carry_s;
    end else if ((state_r == MUL) && last_step_s) begin
      X     <= acc_nxt_s[WIDTH-1:0];
      XADDR <= dst_r;
      zero  <= (acc_nxt_s[WIDTH-1:0] == {WIDTH{1'b0}});
      carry <= mul_carry_s;
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: a cycle-level reference model compared every
// cycle, plus directed vectors with hand-computed results and latencies.
module tb_alu_exec;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] op;
  logic [7:0] A;
  logic [7:0] B;
  logic [1:0] dst;
  logic [7:0] X;
  logic [1:0] XADDR;
  logic       write;
  logic       busy;
  logic       done;
  logic       zero;
  logic       carry;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // reference model state
  bit         m_active;
  int         m_left;
  logic [7:0] m_px;
  logic [1:0] m_paddr;
  logic       m_pz;
  logic       m_pc;
  logic [9:0] m_res;
  logic [7:0] ex;
  logic [1:0] eaddr;
  logic       ez;
  logic       ec;
  logic       ew;
  logic       eb;

  alu_exec #(.WIDTH(8), .ADDR_W(2)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .A(A), .B(B), .dst(dst),
    .X(X), .XADDR(XADDR), .write(write), .busy(busy), .done(done),
    .zero(zero), .carry(carry)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // result arithmetic straight from the op table: returns {zero, carry, x}
  function automatic logic [9:0] model_op(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
    int unsigned ia;
    int unsigned ib;
    int unsigned r;
    logic        c;
    logic [7:0]  x;
    ia = a;
    ib = b;
    c  = 1'b0;
    case (o)
      3'd0: begin r = ia + ib; c = (r > 255); end
      3'd1: begin c = (ia < ib); r = c ? (ia + 256 - ib) : (ia - ib); end
      3'd2: r = ia & ib;
      3'd3: r = ia | ib;
      3'd4: r = ia ^ ib;
      3'd5: begin r = ia * 2; c = (ia >= 128); end
      3'd6: begin r = ia / 2; c = (ia % 2 == 1); end
      default: begin r = ia * ib; c = (r > 255); end
    endcase
    x = r[7:0];
    return {(x == 8'h00), c, x};
  endfunction

  // reference model: an accepted op produces its result 1 (ALU) or 8 (MUL) edges later
  always @(posedge clk) begin
    if (!rst) begin
      m_active = 1'b0; m_left = 0;
      ex = 8'h00; eaddr = 2'd0; ez = 1'b0; ec = 1'b0; ew = 1'b0; eb = 1'b0;
    end else if (ew) begin
      ew = 1'b0;
      eb = 1'b0;
    end else if (m_active) begin
      m_left--;
      if (m_left == 0) begin
        ex = m_px; eaddr = m_paddr; ez = m_pz; ec = m_pc;
        ew = 1'b1;
        m_active = 1'b0;
      end
    end else if (start) begin
      m_res = model_op(op, A, B);
      {m_pz, m_pc, m_px} = m_res;
      m_paddr  = dst;
      m_left   = (op == 3'd7) ? 8 : 1;
      m_active = 1'b1;
      eb = 1'b1;
    end
  end

  // per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("x", {8'h00, X}, {8'h00, ex});
      check("xaddr", {14'd0, XADDR}, {14'd0, eaddr});
      check("write", {15'd0, write}, {15'd0, ew});
      check("done", {15'd0, done}, {15'd0, ew});
      check("busy", {15'd0, busy}, {15'd0, eb});
      check("zero", {15'd0, zero}, {15'd0, ez});
      check("carry", {15'd0, carry}, {15'd0, ec});
    end
  end

  task automatic await_result(input string name, input int lat0, input int lat_exp,
                              input logic [7:0] xx, input logic [1:0] d,
                              input logic cc, input logic zz);
    int lat;
    bit seen;
    lat  = lat0;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      if (write === 1'b1) begin
        seen = 1'b1;
      end else begin
        @(negedge clk);
        lat++;
      end
    end
    check({name, "_write_seen"}, {15'd0, seen}, 16'd1);
    if (seen) begin
      check({name, "_latency"}, lat[15:0], lat_exp[15:0]);
      check({name, "_x"}, {8'h00, X}, {8'h00, xx});
      check({name, "_xaddr"}, {14'd0, XADDR}, {14'd0, d});
      check({name, "_carry"}, {15'd0, carry}, {15'd0, cc});
      check({name, "_zero"}, {15'd0, zero}, {15'd0, zz});
    end
    @(negedge clk);
  endtask

  // drive one op, scramble the inputs right after the latch edge, then check the result
  task automatic run_op(input string name, input logic [2:0] o, input logic [7:0] a,
                        input logic [7:0] b, input logic [1:0] d, input logic [7:0] xx,
                        input logic cc, input logic zz);
    start = 1'b1; op = o; A = a; B = b; dst = d;
    @(negedge clk);
    start = 1'b0; op = ~o; A = ~a; B = b ^ 8'h5A; dst = ~d;
    await_result(name, 1, (o == 3'd7) ? 9 : 2, xx, d, cc, zz);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; op = 3'd0; A = 8'h00; B = 8'h00; dst = 2'd0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("reset_x", {8'h00, X}, 16'h0000);
    check("reset_write", {15'd0, write}, 16'h0000);
    check("reset_busy", {15'd0, busy}, 16'h0000);
    check("reset_carry", {15'd0, carry}, 16'h0000);
    rst = 1'b1;
    @(negedge clk);

    run_op("add",      3'd0, 8'hF0, 8'h20, 2'd2, 8'h10, 1'b1, 1'b0);
    run_op("sub_eq",   3'd1, 8'h05, 8'h05, 2'd1, 8'h00, 1'b0, 1'b1);
    run_op("sub_brw",  3'd1, 8'h03, 8'h05, 2'd3, 8'hFE, 1'b1, 1'b0);
    run_op("mul",      3'd7, 8'h0F, 8'h11, 2'd0, 8'hFF, 1'b0, 1'b0);
    run_op("mul_ovf",  3'd7, 8'h10, 8'h10, 2'd2, 8'h00, 1'b1, 1'b1);
    run_op("shl",      3'd5, 8'h81, 8'h00, 2'd1, 8'h02, 1'b1, 1'b0);
    run_op("shr",      3'd6, 8'h81, 8'h00, 2'd2, 8'h40, 1'b1, 1'b0);
    run_op("and",      3'd2, 8'hF0, 8'h3C, 2'd3, 8'h30, 1'b0, 1'b0);
    run_op("or",       3'd3, 8'h0F, 8'hF0, 2'd0, 8'hFF, 1'b0, 1'b0);
    run_op("xor",      3'd4, 8'hAA, 8'hFF, 2'd1, 8'h55, 1'b0, 1'b0);

    // start pulsed during MUL step 3 must be ignored
    start = 1'b1; op = 3'd7; A = 8'h0F; B = 8'h11; dst = 2'd1;
    @(negedge clk);
    start = 1'b0; A = 8'h00; B = 8'h00;
    repeat (2) @(negedge clk);
    start = 1'b1; op = 3'd0; A = 8'h01; B = 8'h01; dst = 2'd3;
    @(negedge clk);
    start = 1'b0;
    await_result("mul_ignore", 4, 9, 8'hFF, 2'd1, 1'b0, 1'b0);
    repeat (3) @(negedge clk);

    // reset in the middle of a multiply
    start = 1'b1; op = 3'd7; A = 8'h0F; B = 8'h11; dst = 2'd2;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_x", {8'h00, X}, 16'h0000);
    check("rst_mid_busy", {15'd0, busy}, 16'h0000);
    check("rst_mid_write", {15'd0, write}, 16'h0000);
    check("rst_mid_carry", {15'd0, carry}, 16'h0000);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    run_op("add_after_rst", 3'd0, 8'h01, 8'h01, 2'd1, 8'h02, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
